// File: rtl/cpu_6502_pkg.sv
// Shared definitions for the 6502 interrupt controller: register offsets, vector FSM states
// and the fixed-priority encoder.
package cpu_6502_pkg;

  localparam int unsigned MAX_IRQ = 8;
  localparam int unsigned OFF_W   = 5;

  localparam logic [OFF_W-1:0] OFF_STATUS = 5'd0;
  localparam logic [OFF_W-1:0] OFF_MASK   = 5'd1;
  localparam logic [OFF_W-1:0] OFF_MODE   = 5'd2;
  localparam logic [OFF_W-1:0] OFF_ACK    = 5'd3;
  localparam logic [OFF_W-1:0] OFF_ACTIVE = 5'd4;
  localparam logic [OFF_W-1:0] OFF_VEC    = 5'd8;

  localparam logic [15:0] NMI_VEC_ADDR = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC_ADDR = 16'hFFFE;

  typedef enum logic {
    IDLE,
    VEC_HI
  } vec_state_t;

  // Lowest set index wins; an all-zero input encodes as 0.
  function automatic logic [2:0] prio_enc(input logic [MAX_IRQ-1:0] v);
    logic [2:0] enc;
    enc = 3'd0;
    for (int i = int'(MAX_IRQ) - 1; i >= 0; i--) begin
      if (v[i]) enc = 3'(i);
    end
    return enc;
  endfunction

endpackage

// File: rtl/cpu_6502_sync_edge.sv
// Multi-stage synchroniser for asynchronous inputs with a rising-edge detector on the
// synchronised level.
module cpu_6502_sync_edge #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  // Shift chain plus one delayed copy of the synchronised level for edge detection.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stages[i] <= '0;
      prev <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < int'(SYNC_STAGES); i++) stages[i] <= stages[i-1];
      prev <= stages[SYNC_STAGES-1];
    end
  end

  assign sync   = stages[SYNC_STAGES-1];
  assign rise_c = sync & ~prev;

endmodule

// File: rtl/cpu_6502_int_ctrl.sv
// Memory-mapped interrupt controller for the 6502 bus: edge/level sources with masking and
// fixed priority, a stretched NMI pulse, and optional vectored $FFFE/$FFFF override.
module cpu_6502_int_ctrl
  import cpu_6502_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NMI_PULSE   = 4,
  parameter int unsigned VECTORED    = 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               bus_en,
  input  logic [15:0]        addr,
  input  logic               rw,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               data_oe,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               nmi_src,
  output logic               IRQ_N,
  output logic               NMI_N
);

  localparam logic [7:0]  CH_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);
  localparam int unsigned CNT_W   = $clog2(NMI_PULSE + 1);

  logic [NUM_IRQ-1:0] irq_sync;
  logic [NUM_IRQ-1:0] irq_rise_c;
  logic               nmi_sync_unused;
  logic               nmi_rise_c;

  cpu_6502_sync_edge #(.WIDTH(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk    (clk),
    .res    (res),
    .din    (irq_src),
    .sync   (irq_sync),
    .rise_c (irq_rise_c)
  );

  cpu_6502_sync_edge #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk    (clk),
    .res    (res),
    .din    (nmi_src),
    .sync   (nmi_sync_unused),
    .rise_c (nmi_rise_c)
  );

  logic [7:0]       pending, mask, mode;
  logic [7:0]       vec_lo [MAX_IRQ];
  logic [7:0]       vec_hi [MAX_IRQ];
  logic [CNT_W-1:0] nmi_cnt;
  vec_state_t       state, state_nxt;
  logic [2:0]       vec_ch;

  logic [OFF_W-1:0] off;
  logic             win_hit, wr_en, rd_en;
  logic [3:0]       vch;
  logic             vec_ok;
  logic [7:0]       irq_lvl, irq_rise, ack_bits, pending_nxt, active;
  logic             any;
  logic [2:0]       enc;
  logic             fsm_drive, fsm_latch;
  logic [7:0]       fsm_data;

  // Address decode for the register window and per-channel vector slots.
  assign off     = addr[OFF_W-1:0];
  assign win_hit = (addr[15:OFF_W] == BASE_ADDR[15:OFF_W]);
  assign wr_en   = bus_en & ~rw & win_hit;
  assign rd_en   = bus_en & rw & win_hit;
  assign vch     = 4'((off - OFF_VEC) >> 1);
  assign vec_ok  = (off >= OFF_VEC) && (vch < 4'(NUM_IRQ));

  // Pending update: edge channels latch until acked (a new edge beats the ack), level
  // channels simply mirror the synchronised input.
  assign irq_lvl     = 8'(irq_sync);
  assign irq_rise    = 8'(irq_rise_c);
  assign ack_bits    = (wr_en && off == OFF_ACK) ? (data_in & CH_MASK) : 8'h00;
  assign pending_nxt = ((mode & ((pending & ~ack_bits) | irq_rise)) | (~mode & irq_lvl)) & CH_MASK;

  assign active = pending & mask;
  assign any    = |active;
  assign enc    = prio_enc(active);

  // Register file, pending state and the registered IRQ line.
  always_ff @(posedge clk) begin
    if (res) begin
      pending <= 8'h00;
      mask    <= 8'h00;
      mode    <= 8'h00;
      IRQ_N   <= 1'b1;
      for (int i = 0; i < int'(MAX_IRQ); i++) begin
        vec_lo[i] <= 8'h00;
        vec_hi[i] <= 8'h00;
      end
    end else begin
      pending <= pending_nxt;
      IRQ_N   <= ~any;
      if (wr_en) begin
        case (off)
          OFF_MASK: mask <= data_in & CH_MASK;
          OFF_MODE: mode <= data_in & CH_MASK;
          default: begin
            if (vec_ok) begin
              if (off[0]) vec_hi[vch[2:0]] <= data_in;
              else        vec_lo[vch[2:0]] <= data_in;
            end
          end
        endcase
      end
    end
  end

  // NMI stretcher: each synchronised rising edge (re)loads the pulse counter.
  always_ff @(posedge clk) begin
    if (res) begin
      nmi_cnt <= '0;
      NMI_N   <= 1'b1;
    end else begin
      if (nmi_rise_c)         nmi_cnt <= CNT_W'(NMI_PULSE);
      else if (nmi_cnt != '0) nmi_cnt <= nmi_cnt - CNT_W'(1);
      NMI_N <= (nmi_cnt == '0);
    end
  end

  // Vector FSM state register and the channel latched on the low-byte fetch.
  always_ff @(posedge clk) begin
    if (res) begin
      state  <= IDLE;
      vec_ch <= 3'd0;
    end else begin
      state <= state_nxt;
      if (fsm_latch) vec_ch <= enc;
    end
  end

  // Vector FSM next state and vector-byte drive.
  always_comb begin
    state_nxt = state;
    fsm_drive = 1'b0;
    fsm_latch = 1'b0;
    fsm_data  = 8'h00;
    if (VECTORED != 0) begin
      case (state)
        IDLE: begin
          if (bus_en && rw && addr == IRQ_VEC_ADDR && any) begin
            fsm_drive = 1'b1;
            fsm_latch = 1'b1;
            fsm_data  = vec_lo[enc];
            state_nxt = VEC_HI;
          end
        end
        VEC_HI: begin
          if (bus_en) begin
            state_nxt = IDLE;
            if (rw && addr == IRQ_VEC_ADDR + 16'd1) begin
              fsm_drive = 1'b1;
              fsm_data  = vec_hi[vec_ch];
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Read data mux: register window first, then the vector override.
  always_comb begin
    data_out = 8'h00;
    data_oe  = 1'b0;
    if (rd_en) begin
      data_oe = 1'b1;
      case (off)
        OFF_STATUS: data_out = pending;
        OFF_MASK:   data_out = mask;
        OFF_MODE:   data_out = mode;
        OFF_ACTIVE: data_out = {any, 4'b0000, enc};
        default: begin
          if (vec_ok) data_out = off[0] ? vec_hi[vch[2:0]] : vec_lo[vch[2:0]];
        end
      endcase
    end else if (fsm_drive) begin
      data_oe  = 1'b1;
      data_out = fsm_data;
    end
  end

endmodule
